// File: rtl/stream_mux_pkg.sv
// Shared types for the streaming N:1 multiplexer: operating mode and packet-lock state.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  typedef enum logic {
    S_ARB  = 1'b0,
    S_LOCK = 1'b1
  } mux_state_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter  int N_CH  = 16,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             found
);

  localparam int IDX_W = $clog2(2 * N_CH);

  logic [2*N_CH-1:0] req2;
  logic [IDX_W-1:0]  idx;

  // Doubling the request vector turns the wrap-around scan into a linear one.
  assign req2 = {req, req};

  // Scan from farthest to nearest so the closest request to ptr is the last one written.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = IDX_W'(ptr) + IDX_W'(i);
      if (req2[idx]) begin
        found = 1'b1;
        grant = (idx >= IDX_W'(N_CH)) ? SEL_W'(idx - IDX_W'(N_CH)) : SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with fixed or round-robin selection, packet locking
// and a single registered output slot.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int SEL_N = 1 << SEL_W;
  // Marks which sel codes name a real channel (matters when N_CH is not a power of 2).
  localparam logic [SEL_N-1:0] CH_MASK = {SEL_N{1'b1}} >> (SEL_N - N_CH);

  mux_mode_e        mode_e;
  mux_state_e       state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic [SEL_W-1:0] arb_grant, grant;
  logic             arb_found, grant_ok;
  logic             slot_free, xfer, beat_last;
  logic [WIDTH-1:0] beat_data;

  assign mode_e = mux_mode_e'(mode);

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .found (arb_found)
  );

  always_comb begin
    grant    = arb_grant;
    grant_ok = arb_found;
    if (state_q == S_LOCK) begin
      grant    = lock_ch_q;
      grant_ok = 1'b1;
    end else if (mode_e == MODE_FIXED) begin
      grant    = sel;
      grant_ok = CH_MASK[sel];
    end
  end

  assign slot_free = ~out_valid_q | out_ready;

  // rst_n gates ready so no producer sees a handshake while the block is held in reset.
  always_comb begin
    in_ready  = '0;
    beat_data = '0;
    beat_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = rst_n & slot_free & grant_ok;
        beat_data   = in_data[i*WIDTH +: WIDTH];
        beat_last   = in_last[i];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (slot_free) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = beat_data;
      out_chan_d = grant;
      out_last_d = beat_last;
      if (beat_last) begin
        state_d = S_ARB;
        if (mode_e == MODE_RR)
          rr_ptr_d = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + 1'b1;
      end else begin
        state_d   = S_LOCK;
        lock_ch_d = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ARB;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised scoreboard bench for stream_mux_rr: packet producers, a transaction-level
// reference model and an output monitor, plus a small 5-channel build.
module tb_stream_mux_rr;

  localparam int N   = 16;
  localparam int W   = 8;
  localparam int SW  = 4;
  localparam int N5  = 5;
  localparam int SW5 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, mode, out_ready;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid, in_last, in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_last, out_valid;

  logic           mode5, out_ready5;
  logic [SW5-1:0] sel5;
  logic [N5*W-1:0] in_data5;
  logic [N5-1:0]  in_valid5, in_last5, in_ready5;
  logic [W-1:0]   out_data5;
  logic [SW5-1:0] out_chan5;
  logic           out_last5, out_valid5;

  stream_mux_rr #(.N_CH(N), .WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(N5), .WIDTH(W)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5), .in_data(in_data5),
    .in_valid(in_valid5), .in_last(in_last5), .in_ready(in_ready5),
    .out_data(out_data5), .out_chan(out_chan5), .out_last(out_last5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         chan;
    logic [W-1:0] data;
    bit         last;
  } beat_t;
  beat_t sb[$];

  // Producers: each channel owns at most one packet in flight.
  bit           has_pkt[N];
  int           left[N];
  logic [W-1:0] pdat[N];
  int           fix_len[N];
  bit           en[N];
  int start_pct = 100, gap_pct = 0, ordy_pct = 100;
  bit rst_r = 1'b0, mode_r = 1'b0;
  int sel_r = 0;

  // Reference model state: output slot occupancy, packet owner, round-robin start.
  bit   m_busy = 1'b0, m_free, m_ok, m_xfer;
  int   m_rr = 0, m_owner = -1, m_g;
  logic [N-1:0] m_ready;

  task automatic drive_inputs();
    rst_n     = rst_r;
    mode      = mode_r;
    sel       = SW'(sel_r);
    out_ready = ($urandom_range(99) < ordy_pct);
    for (int c = 0; c < N; c++) begin
      if (en[c] && !has_pkt[c] && ($urandom_range(99) < start_pct)) begin
        has_pkt[c] = 1'b1;
        left[c]    = (fix_len[c] > 0) ? fix_len[c] : int'($urandom_range(1, 4));
        pdat[c]    = W'($urandom);
      end
      in_valid[c]          = has_pkt[c] && en[c] && ($urandom_range(99) >= gap_pct);
      in_last[c]           = has_pkt[c] && (left[c] == 1);
      in_data[c*W +: W]    = has_pkt[c] ? pdat[c] : W'($urandom);
    end
  endtask

  task automatic model_comb();
    m_free = !m_busy || out_ready;
    m_ok   = 1'b0;
    m_g    = 0;
    if (m_owner >= 0) begin
      m_g  = m_owner;
      m_ok = 1'b1;
    end else if (mode == 1'b0) begin
      m_g  = int'(sel);
      m_ok = (m_g < N);
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (!m_ok && in_valid[c]) begin
          m_g  = c;
          m_ok = 1'b1;
        end
      end
    end
    m_ready = '0;
    if (rst_n && m_free && m_ok) m_ready[m_g] = 1'b1;
    m_xfer = rst_n && m_free && m_ok && in_valid[m_g];
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_rr    = 0;
      m_owner = -1;
      sb.delete();
      for (int c = 0; c < N; c++) has_pkt[c] = 1'b0;
    end else if (m_xfer) begin
      beat_t b;
      b.chan = m_g;
      b.data = pdat[m_g];
      b.last = (left[m_g] == 1);
      sb.push_back(b);
      m_busy = 1'b1;
      if (b.last) begin
        m_owner = -1;
        if (mode) m_rr = (m_g + 1) % N;
      end else begin
        m_owner = m_g;
      end
      left[m_g]--;
      pdat[m_g] = W'($urandom);
      if (left[m_g] == 0) has_pkt[m_g] = 1'b0;
    end else if (m_free) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic cycle(input bit rst_mid = 1'b0);
    @(negedge clk);
    drive_inputs();
    #1;
    model_comb();
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, m_busy);
    if (rst_mid) begin
      #2;
      rst_n = 1'b0;
      rst_r = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, '0);
      model_comb();
    end
    @(posedge clk);
    model_update();
  endtask

  // Monitor: every presented beat must match the oldest expected one; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got chan %0d data %0h expected no beat", out_chan, out_data);
        end else begin
          check("out_chan", out_chan, sb[0].chan);
          check("out_data", out_data, sb[0].data);
          check("out_last", out_last, sb[0].last);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic set_all(input bit e, input int flen);
    for (int c = 0; c < N; c++) begin
      en[c]      = e;
      fix_len[c] = flen;
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_data = '0; in_valid = '0; in_last = '0;
    mode5 = 1'b0; sel5 = '0; out_ready5 = 1'b1;
    in_data5 = '0; in_valid5 = '0; in_last5 = '0;
    for (int c = 0; c < N; c++) begin
      has_pkt[c] = 1'b0; left[c] = 0; pdat[c] = '0;
    end
    set_all(1'b1, 1);

    // Held in reset with every channel valid: nothing ready, nothing out.
    repeat (3) cycle();
    rst_r = 1'b1;

    // Fixed select on channel 5, then 15.
    mode_r = 1'b0; sel_r = 5;
    repeat (6) cycle();
    sel_r = 15;
    repeat (6) cycle();

    // Round-robin over all-valid single beats: 0..15 then wrap.
    mode_r = 1'b1;
    repeat (20) cycle();

    // Long packet on ch3 competing with ch7, then a mode flip mid-packet.
    set_all(1'b0, 1);
    en[3] = 1'b1; en[7] = 1'b1; fix_len[3] = 4;
    repeat (12) cycle();
    repeat (2) cycle();
    mode_r = 1'b0; sel_r = 7;
    repeat (10) cycle();

    // Downstream stall for three cycles with a beat held.
    mode_r = 1'b1; set_all(1'b1, 1);
    repeat (3) cycle();
    ordy_pct = 0;
    repeat (3) cycle();
    ordy_pct = 100;
    repeat (4) cycle();

    // Random traffic: variable lengths, valid gaps, backpressure, mode/sel changes.
    start_pct = 40; gap_pct = 30; ordy_pct = 70;
    for (int i = 0; i < 800; i++) begin
      if (i % 16 == 0) begin
        mode_r = 1'($urandom_range(1));
        sel_r  = int'($urandom_range(N - 1));
        for (int c = 0; c < N; c++) begin
          en[c]      = ($urandom_range(99) < 60);
          fix_len[c] = 0;
        end
      end
      cycle();
    end

    // Reset in the middle of traffic, then round-robin restarts from channel 0.
    cycle(1'b1);
    repeat (2) cycle();
    rst_r = 1'b1;
    start_pct = 100; gap_pct = 0; ordy_pct = 100; mode_r = 1'b1;
    set_all(1'b1, 1);
    repeat (18) cycle();

    // Drain everything.
    set_all(1'b0, 1);
    repeat (4) cycle();
    check("scoreboard_empty", sb.size(), 0);

    // Five-channel build: out-of-range select grants nothing, valid select works.
    @(negedge clk);
    mode5 = 1'b0; sel5 = 3'd6; in_valid5 = '1; in_last5 = '1;
    in_data5 = {W'(8'h55), W'(8'h44), W'(8'hA3), W'(8'h22), W'(8'h11)};
    repeat (4) begin
      #1;
      check("n5_in_ready_sel6", in_ready5, '0);
      check("n5_out_valid_sel6", out_valid5, 1'b0);
      @(negedge clk);
    end
    sel5 = 3'd2;
    #1;
    check("n5_in_ready_sel2", in_ready5, 5'b00100);
    @(negedge clk);
    sel5 = 3'd6;
    #1;
    check("n5_out_valid_sel2", out_valid5, 1'b1);
    check("n5_out_chan_sel2", out_chan5, 3'd2);
    check("n5_out_data_sel2", out_data5, 8'hA3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
